// File: rtl/loader_mem_arbiter.sv
// Loader-to-RAM write arbiter: buffers download bytes and drains them on free cycles, then starts the program.
// Optional LOADER_CPU_FREEZE_EN: hold the CPU in wait during a download and drain one entry per cycle.
module loader_mem_arbiter #(
    parameter int unsigned ADDR       = 16,
    parameter int unsigned DATA       = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            ld_download,
    input  logic            ld_wr,
    input  logic [ADDR-1:0] ld_addr,
    input  logic [DATA-1:0] ld_data,
    input  logic            ld_exec_en,
    input  logic [ADDR-1:0] ld_exec_addr,
    output logic            ld_hold,
    input  logic            cpu_mreq,
    output logic            cpu_wait,
    output logic            ram_we,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_din,
    output logic            exec_req,
    output logic [ADDR-1:0] exec_addr,
    output logic            busy,
    output logic            err_ovf
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        EXEC  = 2'd3
    } state_t;

    state_t          state;
    logic [ADDR-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             dl_q;
    logic             exec_pend;
    logic [ADDR-1:0]  exec_target;

    logic             full_c;
    logic             push_c;
    logic             pop_c;
    logic             slot_free_c;
    logic [CNT_W-1:0] count_nxt_c;

`ifdef LOADER_CPU_FREEZE_EN
    logic unused_mreq_c;
    assign unused_mreq_c = cpu_mreq;
    assign slot_free_c   = 1'b1;
`else
    assign slot_free_c   = ~cpu_mreq;
    assign cpu_wait      = 1'b0;
`endif

    // Push/pop decisions and the resulting occupancy
    always_comb begin
        full_c      = 1'b0;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        count_nxt_c = count;
        full_c      = (count == FULL_CNT);
        push_c      = ld_wr && !full_c;
        pop_c       = (count != '0) && ((state == LOAD) || (state == DRAIN)) && slot_free_c;
        count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Buffer storage; contents are don't-care once the pointers are flushed
    always_ff @(posedge clock) begin
        if (push_c) begin
            fifo_addr[wr_ptr] <= ld_addr;
            fifo_data[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dl_q        <= 1'b0;
            exec_pend   <= 1'b0;
            exec_target <= '0;
            ld_hold     <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            exec_req    <= 1'b0;
            exec_addr   <= '0;
            busy        <= 1'b0;
            err_ovf     <= 1'b0;
`ifdef LOADER_CPU_FREEZE_EN
            cpu_wait    <= 1'b0;
`endif
        end else begin
            dl_q     <= ld_download;
            count    <= count_nxt_c;
            ld_hold  <= (count_nxt_c >= HOLD_CNT);
            ram_we   <= pop_c;
            exec_req <= 1'b0;

            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                ram_addr <= fifo_addr[rd_ptr];
                ram_din  <= fifo_data[rd_ptr];
            end
            if (ld_wr && full_c) begin
                err_ovf <= 1'b1;
            end
            // Start address may arrive at any time; the latest pulse wins
            if (ld_exec_en && (state != EXEC)) begin
                exec_pend   <= 1'b1;
                exec_target <= ld_exec_addr;
            end

            case (state)
                IDLE: begin
                    if (ld_download && !dl_q) begin
                        state <= LOAD;
                        busy  <= 1'b1;
`ifdef LOADER_CPU_FREEZE_EN
                        cpu_wait <= 1'b1;
`endif
                    end
                end
                LOAD: begin
                    if (!ld_download) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait until the last popped byte has actually been written
                    if (ld_download) begin
                        state <= LOAD;
                    end else if ((count == '0) && !ram_we) begin
                        if (exec_pend) begin
                            state     <= EXEC;
                            exec_req  <= 1'b1;
                            exec_addr <= exec_target;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef LOADER_CPU_FREEZE_EN
                            cpu_wait <= 1'b0;
`endif
                        end
                    end
                end
                EXEC: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    exec_pend <= 1'b0;
`ifdef LOADER_CPU_FREEZE_EN
                    cpu_wait  <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loader_mem_arbiter.sv
// Directed testbench for loader_mem_arbiter (default build, FIFO_DEPTH = 4).
module tb_loader_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        ld_download;
    logic        ld_wr;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_exec_en;
    logic [15:0] ld_exec_addr;
    logic        ld_hold;
    logic        cpu_mreq;
    logic        cpu_wait;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        exec_req;
    logic [15:0] exec_addr;
    logic        busy;
    logic        err_ovf;

    int vectors;
    int miscompares;

    loader_mem_arbiter #(.ADDR(16), .DATA(8), .FIFO_DEPTH(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ld_download  (ld_download),
        .ld_wr        (ld_wr),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_exec_en   (ld_exec_en),
        .ld_exec_addr (ld_exec_addr),
        .ld_hold      (ld_hold),
        .cpu_mreq     (cpu_mreq),
        .cpu_wait     (cpu_wait),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .exec_req     (exec_req),
        .exec_addr    (exec_addr),
        .busy         (busy),
        .err_ovf      (err_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({ram_we, ld_hold, busy, exec_req, err_ovf, cpu_wait} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000000", {ram_we, ld_hold, busy, exec_req, err_ovf, cpu_wait});
        end
        vectors++;
        if ({ram_addr, ram_din, exec_addr} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_buses: got %h expected 0", {ram_addr, ram_din, exec_addr});
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        cpu_mreq    = 1'b0;
        ld_download = 1'b1;
        ld_wr       = 1'b1;
        ld_addr     = 16'h5200;
        ld_data     = 8'hA5;
        tick();
        ld_wr = 1'b0;
        vectors++;
        if (ram_we !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_k1: got we=%b busy=%b expected we=0 busy=1", ram_we, busy);
        end
        tick();
        vectors++;
        if (ram_we !== 1'b1 || ram_addr !== 16'h5200 || ram_din !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_k2: got we=%b addr=%h din=%h expected we=1 addr=5200 din=a5", ram_we, ram_addr, ram_din);
        end
        tick();
        vectors++;
        if (ram_we !== 1'b0 || ram_addr !== 16'h5200) begin
            miscompares++;
            $display("FAIL basic_k3_hold: got we=%b addr=%h expected we=0 addr=5200", ram_we, ram_addr);
        end
    endtask

    task automatic test_no_exec();
        ld_download = 1'b1;
        tick();
        ld_download = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (exec_req !== 1'b0) begin
                miscompares++;
                $display("FAIL no_exec_req[%0d]: got %b expected 0", i, exec_req);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_exec_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_contention();
        logic [15:0] ea;
        logic [7:0]  ed;
        cpu_mreq    = 1'b1;
        ld_download = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            ld_wr   = 1'b1;
            ld_addr = 16'(16'h7000 + i);
            ld_data = 8'(8'h10 + i);
            tick();
            vectors++;
            if (ram_we !== 1'b0 || ld_hold !== (i == 2)) begin
                miscompares++;
                $display("FAIL cont_fill[%0d]: got we=%b hold=%b expected we=0 hold=%b", i, ram_we, ld_hold, (i == 2));
            end
        end
        ld_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (ram_we !== 1'b0 || ld_hold !== 1'b1) begin
                miscompares++;
                $display("FAIL cont_blocked[%0d]: got we=%b hold=%b expected we=0 hold=1", i, ram_we, ld_hold);
            end
        end
        cpu_mreq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ea = 16'(16'h7000 + i);
            ed = 8'(8'h10 + i);
            vectors++;
            if (ram_we !== 1'b1 || ram_addr !== ea || ram_din !== ed || ld_hold !== 1'b0) begin
                miscompares++;
                $display("FAIL cont_drain[%0d]: got we=%b addr=%h din=%h hold=%b expected we=1 addr=%h din=%h hold=0",
                         i, ram_we, ram_addr, ram_din, ld_hold, ea, ed);
            end
        end
        tick();
        vectors++;
        if (ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_done: got we=%b expected 0", ram_we);
        end
        ld_download = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_idle_hold();
        ld_wr   = 1'b1;
        ld_addr = 16'h4000;
        ld_data = 8'h3C;
        tick();
        ld_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (ram_we !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_held[%0d]: got we=%b expected 0", i, ram_we);
            end
        end
        ld_download = 1'b1;
        tick();
        tick();
        vectors++;
        if (ram_we !== 1'b1 || ram_addr !== 16'h4000 || ram_din !== 8'h3C) begin
            miscompares++;
            $display("FAIL idle_release: got we=%b addr=%h din=%h expected we=1 addr=4000 din=3c", ram_we, ram_addr, ram_din);
        end
        ld_download = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        int n;
        cpu_mreq    = 1'b1;
        ld_download = 1'b1;
        tick();
        vectors++;
        if (err_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_pre: got %b expected 0", err_ovf);
        end
        for (int i = 0; i < 5; i++) begin
            ld_wr   = 1'b1;
            ld_addr = 16'(16'h8000 + i);
            ld_data = 8'(8'h20 + i);
            tick();
        end
        ld_wr = 1'b0;
        vectors++;
        if (err_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag: got %b expected 1", err_ovf);
        end
        cpu_mreq = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ram_we === 1'b1) begin
                vectors++;
                if (ram_addr !== 16'(16'h8000 + n)) begin
                    miscompares++;
                    $display("FAIL ovf_order[%0d]: got addr=%h expected %h", n, ram_addr, 16'(16'h8000 + n));
                end
                n++;
            end
        end
        vectors++;
        if (n != 4 || err_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_count: got writes=%0d ovf=%b expected writes=4 ovf=1", n, err_ovf);
        end
        ld_download = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_exec();
        logic exp_we;
        logic exp_req;
        logic exp_busy;
        cpu_mreq    = 1'b1;
        ld_download = 1'b1;
        tick();
        ld_exec_en   = 1'b1;
        ld_exec_addr = 16'h6000;
        tick();
        ld_exec_en = 1'b0;
        ld_wr      = 1'b1;
        ld_addr    = 16'h9000;
        ld_data    = 8'h55;
        tick();
        ld_addr = 16'h9001;
        ld_data = 8'h66;
        tick();
        ld_wr       = 1'b0;
        ld_download = 1'b0;
        cpu_mreq    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_we   = (i <= 1);
            exp_req  = (i == 3);
            exp_busy = (i <= 3);
            vectors++;
            if (ram_we !== exp_we || exec_req !== exp_req || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL exec_seq[%0d]: got we=%b req=%b busy=%b expected we=%b req=%b busy=%b",
                         i, ram_we, exec_req, busy, exp_we, exp_req, exp_busy);
            end
            if (i == 0) begin
                vectors++;
                if (ram_addr !== 16'h9000 || ram_din !== 8'h55) begin
                    miscompares++;
                    $display("FAIL exec_first_byte: got addr=%h din=%h expected 9000 55", ram_addr, ram_din);
                end
            end
            if (i == 3) begin
                vectors++;
                if (exec_addr !== 16'h6000) begin
                    miscompares++;
                    $display("FAIL exec_addr: got %h expected 6000", exec_addr);
                end
            end
`ifndef LOADER_CPU_FREEZE_EN
            vectors++;
            if (cpu_wait !== 1'b0) begin
                miscompares++;
                $display("FAIL exec_cpu_wait[%0d]: got %b expected 0", i, cpu_wait);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_drain();
        cpu_mreq    = 1'b1;
        ld_download = 1'b1;
        tick();
        ld_exec_en   = 1'b1;
        ld_exec_addr = 16'h7777;
        tick();
        ld_exec_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_wr   = 1'b1;
            ld_addr = 16'(16'hA000 + i);
            ld_data = 8'(8'h40 + i);
            tick();
        end
        ld_wr       = 1'b0;
        ld_download = 1'b0;
        tick();
        cpu_mreq = 1'b0;
        tick();
        vectors++;
        if (ram_we !== 1'b1 || ram_addr !== 16'hA000) begin
            miscompares++;
            $display("FAIL rst_pre_write: got we=%b addr=%h expected we=1 addr=a000", ram_we, ram_addr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({ram_we, busy, ld_hold, err_ovf, exec_req} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_async: got we/busy/hold/ovf/req=%b expected 00000", {ram_we, busy, ld_hold, err_ovf, exec_req});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (ram_we !== 1'b0 || exec_req !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_quiet[%0d]: got we=%b req=%b expected 0 0", i, ram_we, exec_req);
            end
        end
        ld_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (ram_we !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_flushed[%0d]: got we=%b expected 0", i, ram_we);
            end
        end
        ld_download = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (exec_req !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_no_exec[%0d]: got req=%b expected 0", i, exec_req);
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        ld_download  = 1'b0;
        ld_wr        = 1'b0;
        ld_addr      = 16'h0;
        ld_data      = 8'h0;
        ld_exec_en   = 1'b0;
        ld_exec_addr = 16'h0;
        cpu_mreq     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        test_basic();
        test_no_exec();
        test_contention();
        test_idle_hold();
        test_overflow();
        test_exec();
        test_no_exec();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
